imm_extender_pipe: RTL and testbench

- Parametrised, pipelined immediate/operand extender for the MIPS datapath; generalises the fixed 16->32 sign extender.
- Supports sign-extend, zero-extend and load-upper modes with a valid/ready handshake.
- Has a 2-entry elastic buffer, so decode can run while execute stalls without losing operands.
- Sits between instruction decode and the ALU B-operand mux.

---
 rtl/imm_ext_pkg.sv | 21 ++
 rtl/imm_extender_pipe_if.sv | 25 ++
 rtl/imm_extender_pipe_core.sv | 51 +++++
 rtl/imm_extender_pipe.sv | 110 +++++++++++
 tb/tb_imm_extender_pipe.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate extender: operand modes and buffer FSM states.
package imm_ext_pkg;

  typedef enum logic [2:0] {
    MODE_SEXT = 3'd0,
    MODE_ZEXT = 3'd1,
    MODE_LUI  = 3'd2,
    MODE_RSVD = 3'd3,
    MODE_LB   = 3'd4,
    MODE_LBU  = 3'd5,
    MODE_LH   = 3'd6,
    MODE_LHU  = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/imm_extender_pipe_if.sv
// Decode-side and ALU-side valid/ready handshake bundle for the immediate extender.
interface imm_extender_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_neg;
  logic             out_bad_mode;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_neg, out_bad_mode
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_neg, out_bad_mode
  );
endinterface

// File: rtl/imm_extender_pipe_core.sv
// Combinational immediate extender (sign/zero/load-upper); IMM_EXT_LOAD_MODES_EN adds LB/LBU/LH/LHU.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int LUI_SHIFT = 16
) (
  input  logic [IN_W-1:0]  data,
  input  logic [2:0]       mode,
  output logic [OUT_W-1:0] result,
  output logic             bad
);

  logic signed [IN_W-1:0]  data_s;
  logic signed [OUT_W-1:0] sext;
  logic        [OUT_W-1:0] zext;
  logic        [OUT_W-1:0] lui;

  assign data_s = signed'(data);
  assign sext   = OUT_W'(data_s);
  assign zext   = OUT_W'(data);
  assign lui    = zext << LUI_SHIFT;

`ifdef IMM_EXT_LOAD_MODES_EN
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_s = signed'(data[7:0]);
  assign half_s = signed'(data[15:0]);
`endif

  always_comb begin
    result = zext;
    bad    = 1'b0;
    case (mode_e'(mode))
      MODE_SEXT: result = sext;
      MODE_ZEXT: result = zext;
      MODE_LUI:  result = lui;
`ifdef IMM_EXT_LOAD_MODES_EN
      MODE_LB:   result = OUT_W'(byte_s);
      MODE_LBU:  result = OUT_W'(data[7:0]);
      MODE_LH:   result = OUT_W'(half_s);
      MODE_LHU:  result = OUT_W'(data[15:0]);
`endif
      // Unsupported modes still deliver the zero-extended value, flagged bad.
      default:   bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extender_pipe.sv
// Pipelined immediate extender with a 2-entry head/skid buffer; optional load modes via IMM_EXT_LOAD_MODES_EN.
module imm_extender_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int LUI_SHIFT = 16
) (
  input logic                clk,
  input logic                rst,
  imm_extender_pipe_if.slave bus
);

  logic [OUT_W-1:0] ext_data;
  logic             ext_bad;

  imm_ext_core #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .LUI_SHIFT (LUI_SHIFT)
  ) u_core (
    .data   (bus.in_data),
    .mode   (bus.in_mode),
    .result (ext_data),
    .bad    (ext_bad)
  );

  state_e           state_p0;
  state_e           state_nxt;
  logic             rdy_p0;
  logic [OUT_W-1:0] head_data_p0;
  logic             head_bad_p0;
  logic [OUT_W-1:0] skid_data_p0;
  logic             skid_bad_p0;
  logic             push;
  logic             pop;
  logic             load_head_new;
  logic             load_head_skid;
  logic             load_skid;

  assign push = bus.in_valid & rdy_p0;
  assign pop  = (state_p0 != ST_EMPTY) & bus.out_ready;

  always_comb begin
    state_nxt      = state_p0;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_p0)
      ST_EMPTY: begin
        if (push) begin
          state_nxt     = ST_ONE;
          load_head_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && !pop) begin
          state_nxt = ST_TWO;
          load_skid = 1'b1;
        end else if (pop && !push) begin
          state_nxt = ST_EMPTY;
        end else if (push && pop) begin
          load_head_new = 1'b1;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_nxt      = ST_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Stage p0: extended operand captured into head or skid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0     <= ST_EMPTY;
      rdy_p0       <= 1'b1;
      head_data_p0 <= '0;
      head_bad_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      // in_ready is a flop so out_ready never reaches it combinationally.
      rdy_p0   <= (state_nxt != ST_TWO);
      if (load_head_new) begin
        head_data_p0 <= ext_data;
        head_bad_p0  <= ext_bad;
      end else if (load_head_skid) begin
        head_data_p0 <= skid_data_p0;
        head_bad_p0  <= skid_bad_p0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data_p0 <= ext_data;
      skid_bad_p0  <= ext_bad;
    end
  end

  assign bus.in_ready     = rdy_p0;
  assign bus.out_valid    = (state_p0 != ST_EMPTY);
  assign bus.out_data     = head_data_p0;
  assign bus.out_neg      = head_data_p0[OUT_W-1];
  assign bus.out_bad_mode = head_bad_p0;

endmodule

// File: tb/tb_imm_extender_pipe.sv
// Directed plus randomized bench for imm_extender_pipe against a FIFO-level reference model.
module tb_imm_extender_pipe;

  localparam int IN_W      = 16;
  localparam int OUT_W     = 32;
  localparam int LUI_SHIFT = 16;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  imm_extender_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  imm_extender_pipe #(
    .IN_W      (IN_W),
    .OUT_W     (OUT_W),
    .LUI_SHIFT (LUI_SHIFT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_data(input logic [15:0] d, input logic [2:0] m);
    longint v;
    v = longint'(d);
    case (m)
      3'd0: if (d >= 16'h8000) v = v - 65536;
      3'd2: v = v * (longint'(1) << LUI_SHIFT);
`ifdef IMM_EXT_LOAD_MODES_EN
      3'd4: begin v = v % 256; if (v >= 128) v = v - 256; end
      3'd5: v = v % 256;
      3'd6: if (d >= 16'h8000) v = v - 65536;
`endif
      default: ;
    endcase
    return v[31:0];
  endfunction

  function automatic logic ref_bad(input logic [2:0] m);
`ifdef IMM_EXT_LOAD_MODES_EN
    return m == 3'd3;
`else
    return m >= 3'd3;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic one_shot(input string tag, input logic [15:0] d, input logic [2:0] m,
                          input logic [31:0] want_d, input logic want_b);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_mode   = m;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk({tag, "_vld"},  32'(bus.out_valid), 32'd1);
    chk({tag, "_data"}, bus.out_data, want_d);
    chk({tag, "_neg"},  32'(bus.out_neg), 32'(want_d[31]));
    chk({tag, "_bad"},  32'(bus.out_bad_mode), 32'(want_b));
    step();
    chk({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
  endtask

  logic [15:0] a_d, b_d, c_d, d0;
  logic [2:0]  a_m, b_m, c_m, m0;
  logic [32:0] q[$];
  logic        can_in, has_out;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    chk("rst_vld",  32'(bus.out_valid), 32'd0);
    chk("rst_rdy",  32'(bus.in_ready), 32'd1);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_neg",  32'(bus.out_neg), 32'd0);
    chk("rst_bad",  32'(bus.out_bad_mode), 32'd0);
    rst = 1'b0;
    step();

    one_shot("sext", 16'h8001, 3'd0, 32'hFFFF8001, 1'b0);
    one_shot("zext", 16'h8001, 3'd1, 32'h00008001, 1'b0);
    one_shot("lui",  16'h1234, 3'd2, 32'h12340000, 1'b0);
    one_shot("lui_hi", 16'hFFFF, 3'd2, 32'hFFFF0000, 1'b0);
    one_shot("mode3", 16'hC0DE, 3'd3, 32'h0000C0DE, 1'b1);
`ifdef IMM_EXT_LOAD_MODES_EN
    one_shot("lb",  16'h0080, 3'd4, 32'hFFFFFF80, 1'b0);
    one_shot("lhu", 16'h8000, 3'd7, 32'h00008000, 1'b0);
`else
    one_shot("lb",  16'h0080, 3'd4, 32'h00000080, 1'b1);
    one_shot("lhu", 16'h8000, 3'd7, 32'h00008000, 1'b1);
`endif

    // Backpressure: A and B fill the buffer, C waits upstream.
    a_d = 16'($urandom); a_m = 3'($urandom_range(0, 7));
    b_d = 16'($urandom); b_m = 3'($urandom_range(0, 7));
    c_d = 16'($urandom); c_m = 3'($urandom_range(0, 7));
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.in_data = a_d; bus.in_mode = a_m;
    step();
    chk("bp_a_rdy", 32'(bus.in_ready), 32'd1);
    chk("bp_a_dat", bus.out_data, ref_data(a_d, a_m));
    bus.in_data = b_d; bus.in_mode = b_m;
    step();
    chk("bp_b_rdy", 32'(bus.in_ready), 32'd0);
    chk("bp_b_dat", bus.out_data, ref_data(a_d, a_m));
    bus.in_data = c_d; bus.in_mode = c_m;
    step();
    chk("bp_stall_rdy", 32'(bus.in_ready), 32'd0);
    chk("bp_stall_dat", bus.out_data, ref_data(a_d, a_m));
    chk("bp_stall_bad", 32'(bus.out_bad_mode), 32'(ref_bad(a_m)));
    step();
    chk("bp_stall2_dat", bus.out_data, ref_data(a_d, a_m));
    bus.out_ready = 1'b1;
    step();
    chk("bp_out_b", bus.out_data, ref_data(b_d, b_m));
    chk("bp_out_b_vld", 32'(bus.out_valid), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_out_c", bus.out_data, ref_data(c_d, c_m));
    chk("bp_out_c_bad", 32'(bus.out_bad_mode), 32'(ref_bad(c_m)));
    step();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Continuous stream through the ONE state with simultaneous push/pop.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d0 = 16'($urandom); m0 = 3'($urandom_range(0, 7));
      bus.in_valid = 1'b1; bus.in_data = d0; bus.in_mode = m0;
      step();
      chk("str_vld", 32'(bus.out_valid), 32'd1);
      chk("str_dat", bus.out_data, ref_data(d0, m0));
      chk("str_rdy", 32'(bus.in_ready), 32'd1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("str_end", 32'(bus.out_valid), 32'd0);

    // Random traffic against a capacity-2 FIFO model.
    for (int i = 0; i < 300; i++) begin
      d0 = 16'($urandom); m0 = 3'($urandom_range(0, 7));
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = d0;
      bus.in_mode   = m0;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      has_out = (q.size() != 0);
      can_in  = (q.size() < 2);
      chk("rnd_vld", 32'(bus.out_valid), 32'(has_out));
      chk("rnd_rdy", 32'(bus.in_ready), 32'(can_in));
      if (has_out) begin
        chk("rnd_dat", bus.out_data, q[0][31:0]);
        chk("rnd_bad", 32'(bus.out_bad_mode), 32'(q[0][32]));
      end
      if (has_out && bus.out_ready) void'(q.pop_front());
      if (can_in && bus.in_valid) q.push_back({ref_bad(m0), ref_data(d0, m0)});
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("rnd_drain", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset while the buffer is full.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1; bus.in_data = 16'h1111; bus.in_mode = 3'd1;
    step();
    bus.in_data = 16'h2222;
    step();
    bus.in_valid = 1'b0;
    chk("full_rdy", 32'(bus.in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vld",  32'(bus.out_valid), 32'd0);
    chk("arst_rdy",  32'(bus.in_ready), 32'd1);
    chk("arst_data", bus.out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    one_shot("post_rst", 16'hFFFE, 3'd0, 32'hFFFFFFFE, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
